// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the multi-channel clock divider.
// Optional feature macro used by the top: CLKDIV_SYNC_EN.
package clkdiv_pkg;

  localparam int CLKDIV_DIV_W        = 20;
  localparam int CLKDIV_DEFAULT_HALF = 500000;
  localparam int CLKDIV_MAX_CH       = 16;

  typedef logic [CLKDIV_DIV_W-1:0] div_t;
  typedef logic [3:0]              ch_idx_t;

  // Channel-index width; a single channel still gets a 1-bit select.
  function automatic int clkdiv_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider slice: counter, active half-period, one-deep pending slot,
// 50%-duty output and registered toggle strobe. New half-periods are only
// adopted at a half-period boundary (or at once when idle / on sync).
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int DIV_W        = CLKDIV_DIV_W,
  parameter int DEFAULT_HALF = CLKDIV_DEFAULT_HALF
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_sync,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_load_half,
  output logic             o_clk,
  output logic             o_tick,
  output logic             o_busy
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_half;
  logic [DIV_W-1:0] r_pend;
  logic             r_busy;
  logic             r_clk;
  logic             r_tick;

  logic [DIV_W-1:0] w_half_m1;
  logic             w_terminal;

  assign w_half_m1  = r_half - DIV_W'(1);
  assign w_terminal = (r_cnt == w_half_m1);

  // Count, toggle at terminal count, and adopt pending half-periods only at safe points.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_cnt  <= '0;
      r_half <= DIV_W'(DEFAULT_HALF);
      r_pend <= '0;
      r_busy <= 1'b0;
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (i_sync) begin
        r_cnt <= '0;
        r_clk <= 1'b0;
        if (r_busy) begin
          r_half <= r_pend;
          r_busy <= 1'b0;
        end
      end else if (r_half == '0) begin
        r_cnt <= '0;
        r_clk <= 1'b0;
        if (r_busy) begin
          r_half <= r_pend;
          r_busy <= 1'b0;
        end
      end else if (w_terminal) begin
        r_cnt <= '0;
        // Switching to disabled parks the output low instead of toggling.
        if (r_busy && (r_pend == '0)) begin
          r_clk <= 1'b0;
        end else begin
          r_clk  <= ~r_clk;
          r_tick <= 1'b1;
        end
        if (r_busy) begin
          r_half <= r_pend;
          r_busy <= 1'b0;
        end
      end else begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
      // A load is only strobed while not busy, so it never collides with an apply.
      if (i_load) begin
        r_pend <= i_load_half;
        r_busy <= 1'b1;
      end
    end
  end

  assign o_clk  = r_clk;
  assign o_tick = r_tick;
  assign o_busy = r_busy;

endmodule

// File: rtl/multi_channel_clock_divider.sv
// NUM_CH independent glitch-free programmable clock dividers sharing one
// valid/ready configuration port.
// Macro CLKDIV_SYNC_EN adds sync_in, which phase-aligns all channels.
module multi_channel_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DIV_W        = CLKDIV_DIV_W,
  parameter int DEFAULT_HALF = CLKDIV_DEFAULT_HALF,
  localparam int CH_W        = clkdiv_idx_w(NUM_CH)
) (
  input  logic              clk_in,
  input  logic              rstn,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync_in,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_half,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy
);

  logic [NUM_CH-1:0] w_busy;
  logic [NUM_CH-1:0] w_load;
  logic              w_ready;
  logic              w_sync;

`ifdef CLKDIV_SYNC_EN
  assign w_sync = sync_in;
`else
  assign w_sync = 1'b0;
`endif

  // Ready reflects the addressed channel's busy flag; unmapped indices are always ready.
  always_comb begin
    w_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) w_ready = ~w_busy[i];
    end
  end

  assign cfg_ready = w_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_load[g] = cfg_valid & w_ready & (cfg_ch == CH_W'(g));

    clkdiv_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_HALF(DEFAULT_HALF)
    ) u_ch (
      .i_clk      (clk_in),
      .i_rstn     (rstn),
      .i_sync     (w_sync),
      .i_load     (w_load[g]),
      .i_load_half(cfg_half),
      .o_clk      (clk_out[g]),
      .o_tick     (tick[g]),
      .o_busy     (w_busy[g])
    );
  end

  assign busy = w_busy;

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Self-checking bench for multi_channel_clock_divider (small DEFAULT_HALF so
// full periods fit in a short run). Honours CLKDIV_SYNC_EN when defined.
module tb_multi_channel_clock_divider;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 20;
  localparam int DEF    = 20;

  logic              clk_in = 1'b0;
  logic              rstn;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_ch;
  logic [DIV_W-1:0]  cfg_half;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] busy;
`ifdef CLKDIV_SYNC_EN
  logic              sync_in;
`endif

  multi_channel_clock_divider #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_HALF(DEF)
  ) dut (
    .clk_in   (clk_in),
    .rstn     (rstn),
`ifdef CLKDIV_SYNC_EN
    .sync_in  (sync_in),
`endif
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_half (cfg_half),
    .clk_out  (clk_out),
    .tick     (tick),
    .busy     (busy)
  );

  initial forever #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: each channel is described by its active half-period, the
  // absolute cycle at which its next boundary falls, its output level and an
  // optional pending value.
  int  t = 0;
  bit  m_up = 1'b0;
  int  m_half [NUM_CH];
  int  m_next [NUM_CH];
  int  m_pval [NUM_CH];
  bit  m_pv   [NUM_CH];
  bit  m_lvl  [NUM_CH];
  bit  m_tick [NUM_CH];
  int  last_tick [NUM_CH];
  bit  seen_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, t, act, exp);
    end
  endtask

  task automatic apply_pending(input int c);
    if (m_pv[c]) begin
      m_half[c] = m_pval[c];
      m_pv[c]   = 1'b0;
    end
  endtask

  task automatic cycle(input bit r, input bit s, input bit v, input int ch, input int hv);
    bit erdy, acc;
    logic [NUM_CH-1:0] ec, et, eb;
    rstn      = r;
    cfg_valid = v;
    cfg_ch    = 2'(ch);
    cfg_half  = DIV_W'(hv);
`ifdef CLKDIV_SYNC_EN
    sync_in   = s;
`endif
    #1;
    erdy = (ch < NUM_CH) ? !m_pv[ch] : 1'b1;
    if (m_up && r) chk("cfg_ready", 32'(cfg_ready), 32'(erdy));
    seen_rdy = cfg_ready;
    acc = r && v && erdy && (ch < NUM_CH);
    @(posedge clk_in);
    t++;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!r) begin
        m_half[c] = DEF; m_pv[c] = 1'b0; m_lvl[c] = 1'b0; m_tick[c] = 1'b0;
        m_next[c] = t + DEF;
      end else begin
        m_tick[c] = 1'b0;
        if (s) begin
          apply_pending(c);
          m_lvl[c]  = 1'b0;
          m_next[c] = t + m_half[c];
        end else if (m_half[c] == 0) begin
          if (m_pv[c]) begin
            apply_pending(c);
            m_lvl[c]  = 1'b0;
            m_next[c] = t + m_half[c];
          end
        end else if (t == m_next[c]) begin
          apply_pending(c);
          if (m_half[c] == 0) m_lvl[c] = 1'b0;
          else begin
            m_lvl[c]  = ~m_lvl[c];
            m_tick[c] = 1'b1;
            m_next[c] = t + m_half[c];
          end
        end
      end
    end
    if (acc) begin
      m_pv[ch]   = 1'b1;
      m_pval[ch] = hv;
    end
    if (!r) m_up = 1'b1;
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      ec[c] = m_lvl[c];
      et[c] = m_tick[c];
      eb[c] = m_pv[c];
      if (tick[c] === 1'b1) last_tick[c] = t;
    end
    if (m_up) begin
      chk("clk_out", 32'(clk_out), 32'(ec));
      chk("tick",    32'(tick),    32'(et));
      chk("busy",    32'(busy),    32'(eb));
    end
    @(negedge clk_in);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  // Hold valid until accepted; returns how many cycles it was held off.
  task automatic send(input int ch, input int hv, output int held);
    held = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(1'b1, 1'b0, 1'b1, ch, hv);
      if (seen_rdy) return;
      held++;
    end
    chk("send_timeout", 32'(ch), 32'hFFFF_FFFF);
  endtask

  task automatic wait_tick(input int c, output int when);
    when = -1;
    for (int i = 0; i < 200; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 0, 0);
      if (tick[c] === 1'b1) begin
        when = t;
        return;
      end
    end
    chk("tick_timeout", 32'(c), 32'hFFFF_FFFF);
  endtask

  task automatic wait_idle(input int c);
    for (int i = 0; i < 200; i++) begin
      if (busy[c] === 1'b0) return;
      cycle(1'b1, 1'b0, 1'b0, 0, 0);
    end
    chk("busy_timeout", 32'(c), 32'hFFFF_FFFF);
  endtask

  typedef struct {
    int          ch;
    int          half;
    bit          exp_ready;
    logic [3:0]  exp_busy;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int held, t_a, t_b, t_r, rises, ticks, r0, r1, f0;
    bit prev;

    tbl[0] = '{ch: 0, half: 3, exp_ready: 1'b1, exp_busy: 4'b0001};
    tbl[1] = '{ch: 0, half: 5, exp_ready: 1'b0, exp_busy: 4'b0001};
    tbl[2] = '{ch: 1, half: 0, exp_ready: 1'b1, exp_busy: 4'b0011};
    tbl[3] = '{ch: 3, half: 2, exp_ready: 1'b1, exp_busy: 4'b1011};
    tbl[4] = '{ch: 2, half: 4, exp_ready: 1'b1, exp_busy: 4'b1111};
    tbl[5] = '{ch: 1, half: 7, exp_ready: 1'b0, exp_busy: 4'b1111};

    rstn = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_half = '0;
`ifdef CLKDIV_SYNC_EN
    sync_in = 1'b0;
`endif
    @(negedge clk_in);

    // Reset state
    cycle(1'b0, 1'b0, 1'b0, 0, 0);
    chk("rst_clk_out", 32'(clk_out), 32'h0);
    chk("rst_tick",    32'(tick),    32'h0);
    chk("rst_busy",    32'(busy),    32'h0);
    t_r = t;

    // Default free-run: period 2*DEF, high DEF, tick every DEF
    rises = 0; ticks = 0; r0 = -1; r1 = -1; f0 = -1; prev = 1'b0;
    for (int i = 0; i < 5 * DEF; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 0, 0);
      if (tick[0] === 1'b1) ticks++;
      if (clk_out[0] === 1'b1 && !prev) begin
        if (rises == 0) r0 = t - t_r; else if (rises == 1) r1 = t - t_r;
        rises++;
      end
      if (clk_out[0] === 1'b0 && prev && f0 < 0) f0 = t - t_r;
      prev = clk_out[0];
    end
    chk("def_first_rise", 32'(r0), 32'(DEF));
    chk("def_period",     32'(r1 - r0), 32'(2 * DEF));
    chk("def_high",       32'(f0 - r0), 32'(DEF));
    chk("def_ticks",      32'(ticks), 32'd5);

    // Table of config handshakes with fixed expected ready / busy
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, 1'b1, tbl[i].ch, tbl[i].half);
      chk("tbl_ready", 32'(seen_rdy), 32'(tbl[i].exp_ready));
      chk("tbl_busy",  32'(busy),     32'(tbl[i].exp_busy));
    end
    idle(40);

    // Mid-half reprogram of ch1 to 3
    cycle(1'b0, 1'b0, 1'b0, 0, 0);
    idle(5);
    send(1, 3, held);
    chk("s2_busy_set", 32'(busy[1]), 32'd1);
    wait_idle(1);
    wait_tick(1, t_a);
    wait_tick(1, t_b);
    chk("s2_half3", 32'(t_b - t_a), 32'd3);

    // ch2 disable then re-enable with half=2
    send(2, 0, held);
    wait_idle(2);
    chk("s3_low_at_off", 32'(clk_out[2]), 32'd0);
    idle(10);
    chk("s3_stays_low", 32'(clk_out[2]), 32'd0);
    send(2, 2, held);
    chk("s3_busy_one", 32'(busy[2]), 32'd1);
    idle(1);
    chk("s3_applied", 32'(busy[2]), 32'd0);
    wait_tick(2, t_a);
    wait_tick(2, t_b);
    chk("s3_half2", 32'(t_b - t_a), 32'd2);

    // Back-to-back configs to ch3: second held until first applied
    send(3, 5, held);
    send(3, 9, held);
    chk("s4_held", 32'(held != 0), 32'd1);
    t_a = last_tick[3];
    wait_idle(3);
    chk("s4_first_half", 32'(last_tick[3] - t_a), 32'd5);
    wait_tick(3, t_a);
    wait_tick(3, t_b);
    chk("s4_second_half", 32'(t_b - t_a), 32'd9);

    // Reset with a pending config on ch0 discards it
    send(0, 7, held);
    cycle(1'b0, 1'b0, 1'b1, 0, 9);
    chk("s5_clk_out", 32'(clk_out), 32'h0);
    chk("s5_busy",    32'(busy),    32'h0);
    t_r = t;
    wait_tick(0, t_a);
    chk("s5_first", 32'(t_a - t_r), 32'(DEF));
    wait_tick(0, t_b);
    chk("s5_default", 32'(t_b - t_a), 32'(DEF));

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit r, s;
      int h;
      r = ($urandom_range(0, 149) != 0);
      s = 1'b0;
`ifdef CLKDIV_SYNC_EN
      s = ($urandom_range(0, 99) == 0);
`endif
      case ($urandom_range(0, 5))
        0: h = 0;
        1: h = 1;
        2: h = 2;
        3: h = 3;
        4: h = 5;
        default: h = 8;
      endcase
      cycle(r, s, $urandom_range(0, 2) == 0, $urandom_range(0, 3), h);
    end

`ifdef CLKDIV_SYNC_EN
    // Sync pulse phase-aligns channels with half 5 and 7
    cycle(1'b0, 1'b0, 1'b0, 0, 0);
    send(0, 5, held);
    send(1, 7, held);
    wait_idle(0);
    wait_idle(1);
    cycle(1'b1, 1'b1, 1'b0, 0, 0);
    chk("s6_clk_out", 32'(clk_out), 32'h0);
    chk("s6_tick",    32'(tick),    32'h0);
    t_r = t;
    wait_tick(0, t_a);
    chk("s6_ch0", 32'(t_a - t_r), 32'd5);
    wait_tick(1, t_b);
    chk("s6_ch1", 32'(t_b - t_r), 32'd7);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
